// File: rtl/pif_regseq.sv
// pif_regseq: register-access sequencer between the I2C slave byte interface
// and the PIF register file. Received bytes are decoded by their 2-bit tag:
//   tag 2'b01 (A_ADDR): load the address pointer with the payload
//   tag 2'b10 (D_ADDR): write the payload to the register at the pointer
//   tag 2'b00 / 2'b11 : invalid, byte discarded and counted as an error
// Slave read requests fetch the register at the pointer and hand the byte
// back on tx_data/tx_valid. Bus accesses abort after TIMEOUT cycles without
// reg_ack. This block is the only master of the register bus, and the
// pointer persists across I2C STOP/START.
//
// Optional feature macro: PIF_REGSEQ_AUTOINC_EN -- when defined, the pointer
// increments (mod 2^ADDR_BITS) after every acked write or read.
//
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   rx_valid, rx_data    received byte strobe and byte ([7:6] tag, [5:0] payload)
//   i2c_stop             STOP condition strobe (no effect on sequencing)
//   tx_req               slave requests the next read byte
//   tx_data, tx_valid    byte returned to the slave, 1-cycle strobe
//   reg_addr, reg_wdata  register bus address / write data
//   reg_we, reg_re       register bus write / read request, held to ack or timeout
//   reg_rdata, reg_ack   register bus read data / access complete
//   busy                 sequencer not idle
//   err_cnt              saturating count of timeouts, overruns and bad tags
module pif_regseq #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned ERR_BITS  = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 i2c_stop,
  input  logic                 tx_req,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [ADDR_BITS-1:0] reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [7:0]           reg_rdata,
  input  logic                 reg_ack,
  output logic                 busy,
  output logic [ERR_BITS-1:0]  err_cnt
);

  localparam int unsigned CNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SUM_BITS = ERR_BITS + 2;
  localparam logic [1:0] TAG_A_ADDR = 2'b01;
  localparam logic [1:0] TAG_D_ADDR = 2'b10;
  localparam logic [ERR_BITS-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [ADDR_BITS-1:0]  ptr, ptr_d, ptr_next_c;
  logic [CNT_BITS-1:0]   cnt, cnt_d;
  logic [7:0]            tx_data_d;
  logic                  tx_valid_d;
  logic [ADDR_BITS-1:0]  reg_addr_d, reg_wdata_d;
  logic                  reg_we_d, reg_re_d, busy_d;
  logic [ERR_BITS-1:0]   err_d;
  logic                  ev_a, ev_b, ev_c;
  logic [SUM_BITS-1:0]   err_sum;
  logic [1:0]            tag_c;
  logic [ADDR_BITS-1:0]  payload_c;
  logic                  tmo_c;
  logic                  unused_ok;

  assign tag_c     = rx_data[7:6];
  assign payload_c = rx_data[ADDR_BITS-1:0];
  // Abort on the last of TIMEOUT request cycles.
  assign tmo_c     = (cnt == CNT_BITS'(TIMEOUT - 1));
  // STOP has no effect on sequencing; the pointer survives it.
  assign unused_ok = i2c_stop;

  // Pointer value after a completed access.
`ifdef PIF_REGSEQ_AUTOINC_EN
  assign ptr_next_c = ptr + ADDR_BITS'(1);
`else
  assign ptr_next_c = ptr;
`endif

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      busy      <= busy_d;
      err_cnt   <= err_d;
    end
  end

  // Next-state and next-output logic. Up to three error events can occur
  // in one cycle (ev_a/b/c); each one counts.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    tx_data_d   = tx_data;
    tx_valid_d  = 1'b0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    ev_a        = 1'b0;
    ev_b        = 1'b0;
    ev_c        = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_valid) begin
          // rx_valid has priority; a coincident read request is lost.
          ev_b = tx_req;
          case (tag_c)
            TAG_A_ADDR: ptr_d = payload_c;
            TAG_D_ADDR: begin
              reg_wdata_d = payload_c;
              reg_addr_d  = ptr;
              reg_we_d    = 1'b1;
              state_d     = ST_WR;
            end
            default: ev_a = 1'b1;
          endcase
        end else if (tx_req) begin
          reg_addr_d = ptr;
          reg_re_d   = 1'b1;
          state_d    = ST_RD;
        end
      end

      ST_WR: begin
        ev_a = rx_valid;
        ev_b = tx_req;
        if (reg_ack) begin
          ptr_d   = ptr_next_c;
          state_d = ST_IDLE;
        end else if (tmo_c) begin
          ev_c    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          reg_we_d = 1'b1;
          cnt_d    = cnt + CNT_BITS'(1);
        end
      end

      ST_RD: begin
        ev_a = rx_valid;
        ev_b = tx_req;
        if (reg_ack) begin
          tx_data_d  = reg_rdata;
          tx_valid_d = 1'b1;
          ptr_d      = ptr_next_c;
          state_d    = ST_IDLE;
        end else if (tmo_c) begin
          tx_data_d  = 8'hFF;
          tx_valid_d = 1'b1;
          ev_c       = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          reg_re_d = 1'b1;
          cnt_d    = cnt + CNT_BITS'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    err_sum = SUM_BITS'(err_cnt) + SUM_BITS'(ev_a) + SUM_BITS'(ev_b) + SUM_BITS'(ev_c);
    err_d   = (err_sum > SUM_BITS'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_BITS-1:0];
  end

endmodule

// File: tb/tb_pif_regseq.sv
// Self-checking bench for pif_regseq: directed scenarios plus a randomized
// sequence scored against a transaction-level model of pointer and errors.
module tb_pif_regseq;

  localparam int TIMEOUT = 15;
  localparam int ERR_MAX = 15;
  localparam logic [1:0] T_A = 2'b01;
  localparam logic [1:0] T_D = 2'b10;
`ifdef PIF_REGSEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       sys_clk, sys_rst;
  logic       rx_valid, i2c_stop, tx_req, reg_ack;
  logic [7:0] rx_data, reg_rdata, tx_data;
  logic       tx_valid, reg_we, reg_re, busy;
  logic [5:0] reg_addr, reg_wdata;
  logic [3:0] err_cnt;

  int n_pass = 0;
  int n_total = 0;
  int m_ptr = 0;
  int m_err = 0;

  pif_regseq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .i2c_stop(i2c_stop),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int err_add(input int e, input int n);
    return (e + n > ERR_MAX) ? ERR_MAX : e + n;
  endfunction

  function automatic int ptr_after_ack(input int p);
    return AUTOINC ? (p + 1) % 64 : p;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst = 1'b1;
    tick;
    tick;
    sys_rst = 1'b0;
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic send_byte(input logic [1:0] tag, input logic [5:0] pay);
    rx_valid = 1'b1;
    rx_data  = {tag, pay};
    tick;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_req;
    tx_req = 1'b1;
    tick;
    tx_req = 1'b0;
  endtask

  // Plays the register-file side for a bounded window: acks on the
  // ack_after-th request cycle (0 = never), optionally injects an A_ADDR
  // byte on request cycle ovr_at, and records what the bus showed.
  task automatic serve(input int ack_after, input logic [7:0] rdata, input int ovr_at,
                       output int req_cycles, output logic [5:0] addr,
                       output logic [5:0] wdata, output int txv_cnt,
                       output logic [7:0] txd);
    req_cycles = 0; txv_cnt = 0; addr = '0; wdata = '0; txd = '0;
    for (int i = 0; i < TIMEOUT + 6; i++) begin
      if (reg_we || reg_re) begin
        req_cycles++;
        if (req_cycles == 1) begin
          addr  = reg_addr;
          wdata = reg_wdata;
        end
      end
      if (tx_valid) begin
        txv_cnt++;
        txd = tx_data;
      end
      reg_ack   = (reg_we || reg_re) && (req_cycles == ack_after);
      reg_rdata = reg_ack ? rdata : 8'($urandom);
      if ((reg_we || reg_re) && req_cycles == ovr_at) begin
        rx_valid = 1'b1;
        rx_data  = {T_A, 6'd7};
      end
      tick;
      rx_valid = 1'b0;
      reg_ack  = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_total++; if ({tx_data, tx_valid} !== 9'h000) $display("FAIL reset_tx: got %h/%b want 00/0", tx_data, tx_valid); else n_pass++;
    n_total++; if ({reg_addr, reg_wdata} !== 12'h000) $display("FAIL reset_bus: got addr %0d wdata %0d want 0/0", reg_addr, reg_wdata); else n_pass++;
    n_total++; if ({reg_we, reg_re, busy} !== 3'b000) $display("FAIL reset_ctl: got we/re/busy %b%b%b want 000", reg_we, reg_re, busy); else n_pass++;
    n_total++; if (err_cnt !== 4'd0) $display("FAIL reset_err: got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_write_basic;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    send_byte(T_A, 6'd2);
    m_ptr = 2;
    send_byte(T_D, 6'd1);
    n_total++; if ({reg_we, busy} !== 2'b11) $display("FAIL wr_latency: got we/busy %b%b want 11", reg_we, busy); else n_pass++;
    serve(3, 8'h00, 0, rc, a, w, tc, d);
    n_total++; if (rc !== 3) $display("FAIL wr_we_cycles: got %0d want 3", rc); else n_pass++;
    n_total++; if (a !== 6'd2 || w !== 6'd1) $display("FAIL wr_addr_data: got %0d/%0d want 2/1", a, w); else n_pass++;
    n_total++; if (err_cnt !== 4'd0) $display("FAIL wr_err: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0 || tc !== 0) $display("FAIL wr_idle: got busy %b txv %0d want 0/0", busy, tc); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
  endtask

  task automatic test_read_basic;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    send_byte(T_A, 6'd5);
    m_ptr = 5;
    pulse_req;
    n_total++; if (reg_re !== 1'b1) $display("FAIL rd_latency: got re %b want 1", reg_re); else n_pass++;
    serve(2, 8'h3C, 0, rc, a, w, tc, d);
    n_total++; if (d !== 8'h3C || tc !== 1) $display("FAIL rd_data: got %h x%0d want 3c x1", d, tc); else n_pass++;
    n_total++; if (a !== 6'd5) $display("FAIL rd_addr: got %0d want 5", a); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
    // Ack in the first request cycle; address shows pointer after the first read.
    pulse_req;
    serve(1, 8'hA5, 0, rc, a, w, tc, d);
    n_total++; if (rc !== 1 || d !== 8'hA5 || tc !== 1) $display("FAIL rd_fast_ack: got cyc %0d data %h x%0d want 1/a5/1", rc, d, tc); else n_pass++;
    n_total++; if (a !== 6'(m_ptr)) $display("FAIL rd_ptr_update: got %0d want %0d", a, m_ptr); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
  endtask

  task automatic test_timeouts;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    send_byte(T_D, 6'h15);
    serve(0, 8'h00, 0, rc, a, w, tc, d);
    m_err = err_add(m_err, 1);
    n_total++; if (rc !== TIMEOUT) $display("FAIL wr_timeout_len: got %0d want %0d", rc, TIMEOUT); else n_pass++;
    n_total++; if (err_cnt !== 4'(m_err)) $display("FAIL wr_timeout_err: got %0d want %0d", err_cnt, m_err); else n_pass++;
    pulse_req;
    serve(0, 8'h00, 0, rc, a, w, tc, d);
    m_err = err_add(m_err, 1);
    n_total++; if (rc !== TIMEOUT) $display("FAIL rd_timeout_len: got %0d want %0d", rc, TIMEOUT); else n_pass++;
    n_total++; if (d !== 8'hFF || tc !== 1) $display("FAIL rd_timeout_data: got %h x%0d want ff x1", d, tc); else n_pass++;
    n_total++; if (a !== 6'(m_ptr)) $display("FAIL timeout_ptr: got %0d want %0d", a, m_ptr); else n_pass++;
    n_total++; if (err_cnt !== 4'(m_err)) $display("FAIL rd_timeout_err: got %0d want %0d", err_cnt, m_err); else n_pass++;
  endtask

  task automatic test_wrap;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    send_byte(T_A, 6'd63);
    m_ptr = 63;
    send_byte(T_D, 6'd10);
    serve(2, 8'h00, 0, rc, a, w, tc, d);
    n_total++; if (a !== 6'd63) $display("FAIL wrap_first: got %0d want 63", a); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
    send_byte(T_D, 6'd11);
    serve(2, 8'h00, 0, rc, a, w, tc, d);
    n_total++; if (a !== 6'(m_ptr) || w !== 6'd11) $display("FAIL wrap_second: got %0d/%0d want %0d/11", a, w, m_ptr); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
  endtask

  task automatic test_collision;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    rx_valid = 1'b1;
    rx_data  = {T_A, 6'd9};
    tx_req   = 1'b1;
    tick;
    rx_valid = 1'b0;
    tx_req   = 1'b0;
    m_ptr = 9;
    m_err = err_add(m_err, 1);
    n_total++; if ({reg_re, busy} !== 2'b00) $display("FAIL collide_no_read: got re/busy %b%b want 00", reg_re, busy); else n_pass++;
    n_total++; if (err_cnt !== 4'(m_err)) $display("FAIL collide_err: got %0d want %0d", err_cnt, m_err); else n_pass++;
    pulse_req;
    serve(1, 8'h5A, 0, rc, a, w, tc, d);
    n_total++; if (a !== 6'd9 || d !== 8'h5A) $display("FAIL collide_ptr: got %0d/%h want 9/5a", a, d); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
  endtask

  task automatic test_random;
    int rc, tc, op, ack; logic [5:0] a, w, pay; logic [7:0] d, rd;
    for (int it = 0; it < 60; it++) begin
      op  = $urandom_range(0, 9);
      pay = 6'($urandom);
      ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      rd  = 8'($urandom);
      if (op <= 1) begin
        send_byte(T_A, pay);
        m_ptr = int'(pay);
        n_total++; if (busy !== 1'b0 || reg_we !== 1'b0) $display("FAIL rnd_aaddr_idle it%0d: busy %b we %b want 0/0", it, busy, reg_we); else n_pass++;
      end else if (op <= 4) begin
        i2c_stop = $urandom_range(0, 1);
        send_byte(T_D, pay);
        i2c_stop = 1'b0;
        serve(ack, 8'h00, 0, rc, a, w, tc, d);
        n_total++;
        if (rc !== (ack == 0 ? TIMEOUT : ack) || a !== 6'(m_ptr) || w !== pay)
          $display("FAIL rnd_write it%0d: cyc %0d addr %0d data %0d want %0d/%0d/%0d", it, rc, a, w, (ack == 0 ? TIMEOUT : ack), m_ptr, pay);
        else n_pass++;
        if (ack == 0) m_err = err_add(m_err, 1); else m_ptr = ptr_after_ack(m_ptr);
      end else if (op <= 7) begin
        pulse_req;
        serve(ack, rd, 0, rc, a, w, tc, d);
        n_total++;
        if (tc !== 1 || d !== (ack == 0 ? 8'hFF : rd) || a !== 6'(m_ptr))
          $display("FAIL rnd_read it%0d: txv %0d data %h addr %0d want 1/%h/%0d", it, tc, d, a, (ack == 0 ? 8'hFF : rd), m_ptr);
        else n_pass++;
        if (ack == 0) m_err = err_add(m_err, 1); else m_ptr = ptr_after_ack(m_ptr);
      end else if (op == 8) begin
        send_byte($urandom_range(0, 1) ? 2'b11 : 2'b00, pay);
        m_err = err_add(m_err, 1);
      end else begin
        i2c_stop = 1'b1;
        tick;
        i2c_stop = 1'b0;
      end
      n_total++; if (err_cnt !== 4'(m_err)) $display("FAIL rnd_err it%0d: got %0d want %0d", it, err_cnt, m_err); else n_pass++;
    end
  endtask

  task automatic test_overrun_saturate;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    do_reset;
    send_byte(T_A, 6'd10);
    m_ptr = 10;
    send_byte(T_D, 6'd33);
    serve(3, 8'h00, 2, rc, a, w, tc, d);
    m_err = err_add(m_err, 1);
    n_total++; if (rc !== 3 || a !== 6'd10 || w !== 6'd33) $display("FAIL ovr_write: got %0d/%0d/%0d want 3/10/33", rc, a, w); else n_pass++;
    n_total++; if (err_cnt !== 4'(m_err)) $display("FAIL ovr_err: got %0d want %0d", err_cnt, m_err); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
    send_byte(T_D, 6'd5);
    serve(1, 8'h00, 0, rc, a, w, tc, d);
    n_total++; if (a !== 6'(m_ptr)) $display("FAIL ovr_ptr_kept: got %0d want %0d", a, m_ptr); else n_pass++;
    m_ptr = ptr_after_ack(m_ptr);
    for (int i = 0; i < 20; i++) begin
      send_byte(i[0] ? 2'b11 : 2'b00, 6'(i));
      m_err = err_add(m_err, 1);
    end
    n_total++; if (err_cnt !== 4'(m_err) || err_cnt !== 4'd15) $display("FAIL err_saturate: got %0d want 15", err_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_access;
    int rc, tc; logic [5:0] a, w; logic [7:0] d;
    int txv_seen;
    send_byte(T_A, 6'd20);
    pulse_req;
    tick;
    tick;
    n_total++; if (reg_re !== 1'b1) $display("FAIL mid_pre_re: got %b want 1", reg_re); else n_pass++;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    m_ptr = 0;
    m_err = 0;
    n_total++; if ({reg_re, reg_we, busy, tx_valid} !== 4'b0000) $display("FAIL mid_reset_ctl: got re/we/busy/txv %b%b%b%b want 0000", reg_re, reg_we, busy, tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00 || reg_addr !== 6'd0 || reg_wdata !== 6'd0 || err_cnt !== 4'd0) $display("FAIL mid_reset_vals: got %h/%0d/%0d/%0d want 00/0/0/0", tx_data, reg_addr, reg_wdata, err_cnt); else n_pass++;
    txv_seen = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (tx_valid || reg_re) txv_seen++;
      tick;
    end
    n_total++; if (txv_seen !== 0) $display("FAIL mid_no_txvalid: got %0d cycles want 0", txv_seen); else n_pass++;
    pulse_req;
    serve(2, 8'h77, 0, rc, a, w, tc, d);
    n_total++; if (a !== 6'd0 || d !== 8'h77) $display("FAIL mid_ptr_reset: got %0d/%h want 0/77", a, d); else n_pass++;
  endtask

  initial begin
    sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; i2c_stop = 1'b0;
    tx_req = 1'b0; reg_ack = 1'b0; reg_rdata = 8'h00;
    test_reset;
    test_write_basic;
    test_read_basic;
    test_timeouts;
    test_wrap;
    test_collision;
    test_random;
    test_overrun_saturate;
    test_reset_mid_access;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
